// File: rtl/div_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the divider front-end (div_arbiter).
//   XLEN              : datapath width
//   op_e              : RV32M divide opcode, encoded as funct3[1:0]
//   state_e           : front-end FSM states
//   INT_MIN, ALL_ONES : special operand/result values
//   op_is_signed/op_is_rem/abs32 : small decode and magnitude helpers
// ----------------------------------------------------------------------------
package div_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

   // DIV and REM are the signed flavours
   function automatic logic op_is_signed(input op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // REM and REMU return the remainder
   function automatic logic op_is_rem(input op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Two's-complement magnitude; INT_MIN maps to 2^31, which is exact unsigned
   function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin one-hot grant: the first asserted valid at or after ptr,
// wrapping at N. Purely combinational.
//   valid [N-1:0]  : request vector
//   ptr   [PW-1:0] : highest-priority index
//   en             : grant enable; grant is all-zero when low
//   grant [N-1:0]  : one-hot grant
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant
);

   logic [PW:0]   sum_s;
   logic [PW-1:0] idx_s;
   logic          found_s;

   // scan from ptr upward with wrap, taking the first valid requester
   always_comb begin
      grant   = {N{1'b0}};
      found_s = 1'b0;
      sum_s   = {(PW+1){1'b0}};
      idx_s   = {PW{1'b0}};
      for (int i = 0; i < N; i++) begin
         sum_s = {1'b0, ptr} + (PW+1)'(i);
         if (sum_s >= (PW+1)'(N)) begin
            sum_s = sum_s - (PW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[PW-1:0];
         if (en && !found_s && valid[idx_s]) begin
            grant[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// ----------------------------------------------------------------------------
// div_arbiter
// Shares one unsigned iterative divider among NUM_REQ requesters. Accepts one
// RV32M DIV/DIVU/REM/REMU op at a time (round-robin), resolves divide-by-zero
// and signed overflow locally, feeds the core unsigned magnitudes over a
// level start/done protocol, fixes up signs and returns a tagged result.
//
// Ports
//   clk, rst (sync, active-high), flush (drop in-flight op)
//   req_valid/req_ready[NUM_REQ], req_op[2*NUM_REQ], req_a/req_b[32*NUM_REQ],
//   req_tag[TAG_W*NUM_REQ]                      : requester side
//   resp_valid, resp_ready, resp_data, resp_tag : result side
//   div_start, div_numerator, div_denominator,
//   div_quotient, div_remainder, div_done       : divider core side
//
// Build option: DIV_RESULT_CACHE_EN adds a one-entry result cache keyed on
// {a, b, signedness}; a hit answers without starting the core.
// ----------------------------------------------------------------------------
module div_arbiter
   import div_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [2*NUM_REQ-1:0]       req_op,
   input  logic [XLEN*NUM_REQ-1:0]    req_a,
   input  logic [XLEN*NUM_REQ-1:0]    req_b,
   input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [XLEN-1:0]            resp_data,
   output logic [TAG_W-1:0]           resp_tag,
   output logic                       div_start,
   output logic [XLEN-1:0]            div_numerator,
   output logic [XLEN-1:0]            div_denominator,
   input  logic [XLEN-1:0]            div_quotient,
   input  logic [XLEN-1:0]            div_remainder,
   input  logic                       div_done
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_r, state_nxt_s;
   logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic                 arb_en_s;
   logic                 accept_s;
   logic [PTR_W-1:0]     gidx_s;
   op_e                  sel_op_s;
   logic [XLEN-1:0]      sel_a_s, sel_b_s;
   logic [TAG_W-1:0]     sel_tag_s;
   logic                 sel_sgn_s, sel_rem_s;

   logic [TAG_W-1:0]     tag_r, tag_nxt_s;
   logic                 is_rem_r, is_rem_nxt_s;
   logic                 neg_q_r, neg_q_nxt_s;
   logic                 neg_r_r, neg_r_nxt_s;
   logic [XLEN-1:0]      resp_data_r, resp_data_nxt_s;
   logic [TAG_W-1:0]     resp_tag_r, resp_tag_nxt_s;
   logic                 resp_valid_r, resp_valid_nxt_s;
   logic                 div_start_r, div_start_nxt_s;
   logic [XLEN-1:0]      div_num_r, div_num_nxt_s;
   logic [XLEN-1:0]      div_den_r, div_den_nxt_s;

   logic [XLEN-1:0]      q_fix_s, r_fix_s;
   logic                 hit_s;
   logic [XLEN-1:0]      hit_quo_s, hit_rem_s;

   // accepting only in IDLE, never while flushing or in reset
   assign arb_en_s = (state_r == ST_IDLE) && !flush && !rst;

   rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_rr (
      .valid (req_valid),
      .ptr   (rr_ptr_r),
      .en    (arb_en_s),
      .grant (grant_s)
   );

   assign req_ready = grant_s;
   assign accept_s  = |(grant_s & req_valid);

   // mux the granted requester's fields
   always_comb begin
      gidx_s    = {PTR_W{1'b0}};
      sel_op_s  = OP_DIV;
      sel_a_s   = 32'd0;
      sel_b_s   = 32'd0;
      sel_tag_s = {TAG_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            gidx_s    = PTR_W'(i);
            sel_op_s  = op_e'(req_op[i*2 +: 2]);
            sel_a_s   = req_a[i*XLEN +: XLEN];
            sel_b_s   = req_b[i*XLEN +: XLEN];
            sel_tag_s = req_tag[i*TAG_W +: TAG_W];
         end else begin
            gidx_s = gidx_s;
         end
      end
   end

   assign sel_sgn_s = op_is_signed(sel_op_s);
   assign sel_rem_s = op_is_rem(sel_op_s);

   // quotient negated when operand signs differ; remainder follows dividend
   assign q_fix_s = neg_q_r ? (32'd0 - div_quotient)  : div_quotient;
   assign r_fix_s = neg_r_r ? (32'd0 - div_remainder) : div_remainder;

`ifdef DIV_RESULT_CACHE_EN
   logic [XLEN-1:0] a_r, b_r;
   logic            sgn_r;
   logic            cache_valid_r;
   logic [XLEN-1:0] cache_a_r, cache_b_r, cache_q_r, cache_rem_r;
   logic            cache_sgn_r;

   assign hit_s     = cache_valid_r && (cache_a_r == sel_a_s) &&
                      (cache_b_r == sel_b_s) && (cache_sgn_r == sel_sgn_s);
   assign hit_quo_s = cache_q_r;
   assign hit_rem_s = cache_rem_r;

   // raw operands of the op in flight, kept as the cache key
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= 32'd0;
         b_r   <= 32'd0;
         sgn_r <= 1'b0;
      end else if (accept_s) begin
         a_r   <= sel_a_s;
         b_r   <= sel_b_s;
         sgn_r <= sel_sgn_s;
      end
   end

   // single-entry cache, refilled on every core completion
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cache_valid_r <= 1'b0;
         cache_a_r     <= 32'd0;
         cache_b_r     <= 32'd0;
         cache_sgn_r   <= 1'b0;
         cache_q_r     <= 32'd0;
         cache_rem_r   <= 32'd0;
      end else if ((state_r == ST_RUN) && div_done) begin
         cache_valid_r <= 1'b1;
         cache_a_r     <= a_r;
         cache_b_r     <= b_r;
         cache_sgn_r   <= sgn_r;
         cache_q_r     <= q_fix_s;
         cache_rem_r   <= r_fix_s;
      end
   end
`else
   assign hit_s     = 1'b0;
   assign hit_quo_s = 32'd0;
   assign hit_rem_s = 32'd0;
`endif

   // next-state and next register values
   always_comb begin
      state_nxt_s      = state_r;
      rr_ptr_nxt_s     = rr_ptr_r;
      tag_nxt_s        = tag_r;
      is_rem_nxt_s     = is_rem_r;
      neg_q_nxt_s      = neg_q_r;
      neg_r_nxt_s      = neg_r_r;
      resp_data_nxt_s  = resp_data_r;
      resp_tag_nxt_s   = resp_tag_r;
      resp_valid_nxt_s = resp_valid_r;
      div_start_nxt_s  = div_start_r;
      div_num_nxt_s    = div_num_r;
      div_den_nxt_s    = div_den_r;
      if (flush) begin
         // drop whatever is in flight; flush beats done and handshake
         state_nxt_s      = ST_IDLE;
         resp_valid_nxt_s = 1'b0;
         div_start_nxt_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  rr_ptr_nxt_s = (gidx_s == PTR_W'(NUM_REQ-1)) ? {PTR_W{1'b0}}
                                                               : gidx_s + 1'b1;
                  tag_nxt_s    = sel_tag_s;
                  is_rem_nxt_s = sel_rem_s;
                  neg_q_nxt_s  = sel_sgn_s && (sel_a_s[XLEN-1] ^ sel_b_s[XLEN-1]);
                  neg_r_nxt_s  = sel_sgn_s && sel_a_s[XLEN-1];
                  if (sel_b_s == 32'd0) begin
                     resp_data_nxt_s  = sel_rem_s ? sel_a_s : ALL_ONES;
                     resp_tag_nxt_s   = sel_tag_s;
                     resp_valid_nxt_s = 1'b1;
                     state_nxt_s      = ST_RESP;
                  end else if (sel_sgn_s && (sel_a_s == INT_MIN) && (sel_b_s == ALL_ONES)) begin
                     resp_data_nxt_s  = sel_rem_s ? 32'd0 : INT_MIN;
                     resp_tag_nxt_s   = sel_tag_s;
                     resp_valid_nxt_s = 1'b1;
                     state_nxt_s      = ST_RESP;
                  end else if (hit_s) begin
                     resp_data_nxt_s  = sel_rem_s ? hit_rem_s : hit_quo_s;
                     resp_tag_nxt_s   = sel_tag_s;
                     resp_valid_nxt_s = 1'b1;
                     state_nxt_s      = ST_RESP;
                  end else begin
                     div_num_nxt_s   = sel_sgn_s ? abs32(sel_a_s) : sel_a_s;
                     div_den_nxt_s   = sel_sgn_s ? abs32(sel_b_s) : sel_b_s;
                     div_start_nxt_s = 1'b1;
                     state_nxt_s     = ST_RUN;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (div_done) begin
                  resp_data_nxt_s  = is_rem_r ? r_fix_s : q_fix_s;
                  resp_tag_nxt_s   = tag_r;
                  resp_valid_nxt_s = 1'b1;
                  div_start_nxt_s  = 1'b0;
                  state_nxt_s      = ST_RESP;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_nxt_s = 1'b0;
                  state_nxt_s      = ST_IDLE;
               end else begin
                  state_nxt_s = ST_RESP;
               end
            end
            default: begin
               state_nxt_s      = ST_IDLE;
               resp_valid_nxt_s = 1'b0;
               div_start_nxt_s  = 1'b0;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r     <= {PTR_W{1'b0}};
         tag_r        <= {TAG_W{1'b0}};
         is_rem_r     <= 1'b0;
         neg_q_r      <= 1'b0;
         neg_r_r      <= 1'b0;
         resp_data_r  <= 32'd0;
         resp_tag_r   <= {TAG_W{1'b0}};
         resp_valid_r <= 1'b0;
         div_start_r  <= 1'b0;
         div_num_r    <= 32'd0;
         div_den_r    <= 32'd0;
      end else begin
         rr_ptr_r     <= rr_ptr_nxt_s;
         tag_r        <= tag_nxt_s;
         is_rem_r     <= is_rem_nxt_s;
         neg_q_r      <= neg_q_nxt_s;
         neg_r_r      <= neg_r_nxt_s;
         resp_data_r  <= resp_data_nxt_s;
         resp_tag_r   <= resp_tag_nxt_s;
         resp_valid_r <= resp_valid_nxt_s;
         div_start_r  <= div_start_nxt_s;
         div_num_r    <= div_num_nxt_s;
         div_den_r    <= div_den_nxt_s;
      end
   end

   assign resp_valid      = resp_valid_r;
   assign resp_data       = resp_data_r;
   assign resp_tag        = resp_tag_r;
   assign div_start       = div_start_r;
   assign div_numerator   = div_num_r;
   assign div_denominator = div_den_r;

endmodule
